// File: rtl/burst_server_pkg.sv
// burst_server_pkg: shared types for the burst_server responder.
// Contents:
//   state_t - FSM state: IDLE (no burst in flight) or BURST (releasing beats)
package burst_server_pkg;

    typedef enum logic {IDLE, BURST} state_t;

endpackage

// File: rtl/burst_server_stream_reg.sv
// stream_reg: one-entry valid/ready register holding a data beat and its last flag.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_load            capture i_data/i_last; the producer only loads when the slot is free or draining
//   i_data, i_last    beat to capture
//   i_ready           downstream accept
//   o_valid, o_data, o_last  registered beat presented downstream
module stream_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // last is dropped together with valid so an empty slot never shows a stale last
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/burst_server.sv
// burst_server: releases BURST_LEN upstream beats per request pulse onto a registered stream.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   i_req_pulse                     one request per high cycle
//   i_clear_ovf                     clears the sticky overflow flag (a drop in the same cycle wins)
//   i_src_valid, i_src_data         upstream beat
//   o_src_ready                     upstream accept (combinational from state, counters, dst stage)
//   o_dst_valid, o_dst_data, o_dst_last, i_dst_ready   registered downstream stream
//   o_busy                          a burst is in flight
//   o_pending                       queued requests not yet started
//   o_overflow                      sticky: a request was dropped
//   o_burst_done                    high on the downstream handshake of the last beat
module burst_server
    import burst_server_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int BURST_LEN   = 4,
    parameter int MAX_PENDING = 3,
    parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_pulse,
    input  logic              i_clear_ovf,
    input  logic              i_src_valid,
    input  logic [DATA_W-1:0] i_src_data,
    output logic              o_src_ready,
    output logic              o_dst_valid,
    output logic [DATA_W-1:0] o_dst_data,
    output logic              o_dst_last,
    input  logic              i_dst_ready,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_overflow,
    output logic              o_burst_done
);

    state_t            r_state;
    state_t            w_next;
    logic [PEND_W-1:0] r_pending;
    logic [7:0]        r_beat_cnt;
    logic              r_overflow;
    logic              w_src_ready;
    logic              w_src_hs;
    logic              w_last_hs;
    logic              w_start;
    logic              w_drop;
    logic              w_req_acc;
    logic              w_dst_valid;
    logic              w_dst_last;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // a finishing burst chains straight into the next one when requests are queued
    always_comb begin
        w_next = (r_state == IDLE) ? ((r_pending != '0) ? BURST : IDLE)
                                   : ((w_last_hs && r_pending == '0) ? IDLE : BURST);
    end

    always_comb begin
        w_src_ready = (r_state == BURST) && (r_beat_cnt < 8'(BURST_LEN)) && (!w_dst_valid || i_dst_ready);
        w_src_hs    = w_src_ready && i_src_valid;
        w_last_hs   = w_src_hs && (r_beat_cnt == 8'(BURST_LEN - 1));
        w_start     = (r_pending != '0) && ((r_state == IDLE) || w_last_hs);
        // a start frees a slot in the same cycle, so a request at the limit is still taken
        w_drop      = i_req_pulse && (r_pending == PEND_W'(MAX_PENDING)) && !w_start;
        w_req_acc   = i_req_pulse && !w_drop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_beat_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= r_pending + PEND_W'(w_req_acc) - PEND_W'(w_start);
            r_beat_cnt <= w_start ? 8'd0 : (w_src_hs ? r_beat_cnt + 8'd1 : r_beat_cnt);
            r_overflow <= w_drop ? 1'b1 : (i_clear_ovf ? 1'b0 : r_overflow);
        end
    end

    stream_reg #(.DATA_W(DATA_W)) u_dst (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_src_hs),
        .i_data  (i_src_data),
        .i_last  (w_last_hs),
        .i_ready (i_dst_ready),
        .o_valid (w_dst_valid),
        .o_data  (o_dst_data),
        .o_last  (w_dst_last)
    );

    assign o_src_ready  = w_src_ready;
    assign o_dst_valid  = w_dst_valid;
    assign o_dst_last   = w_dst_last;
    assign o_busy       = (r_state == BURST);
    assign o_pending    = r_pending;
    assign o_overflow   = r_overflow;
    assign o_burst_done = w_dst_valid && i_dst_ready && w_dst_last;

endmodule

// File: tb/tb_burst_server.sv
// tb_burst_server: self-checking bench for burst_server (directed table, corner sequences, random vs model).
module tb_burst_server;

    localparam int DW = 8;
    localparam int BL = 4;
    localparam int MP = 3;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          clr = 1'b0;
    logic          sv = 1'b0;
    logic          dr = 1'b0;
    logic [DW-1:0] sd = '0;
    logic          src_ready, dst_valid, dst_last, busy, overflow, burst_done;
    logic [DW-1:0] dst_data;
    logic [PW-1:0] pending;

    always #5 clk = ~clk;

    burst_server #(.DATA_W(DW), .BURST_LEN(BL), .MAX_PENDING(MP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_pulse  (req),
        .i_clear_ovf  (clr),
        .i_src_valid  (sv),
        .i_src_data   (sd),
        .o_src_ready  (src_ready),
        .o_dst_valid  (dst_valid),
        .o_dst_data   (dst_data),
        .o_dst_last   (dst_last),
        .i_dst_ready  (dr),
        .o_busy       (busy),
        .o_pending    (pending),
        .o_overflow   (overflow),
        .o_burst_done (burst_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: requests queued as a count, the active burst as beats still to release
    bit      m_known = 0;
    bit      m_act, m_ovf, m_dv, m_dl;
    int      m_pend, m_left;
    logic [DW-1:0] m_dd;

    // DUT outputs captured at the falling edge of the current cycle
    int s_sr, s_dv, s_dl, s_busy, s_ovf, s_done, s_pend, s_dd;

    typedef struct {
        bit req;
        bit dv;
        bit dl;
        bit done;
        bit busy;
        int pend;
        int dd;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_sr();
        return m_act && m_left > 0 && (!m_dv || dr);
    endfunction

    task automatic model_update();
        bit hs, last, start, drop;
        if (!rst_n) begin
            m_act = 0; m_ovf = 0; m_dv = 0; m_dl = 0;
            m_pend = 0; m_left = 0; m_dd = '0; m_known = 1;
        end else begin
            hs    = m_sr() && sv;
            last  = hs && m_left == 1;
            start = (!m_act || last) && m_pend > 0;
            drop  = req && m_pend == MP && !start;
            m_pend = m_pend + ((req && !drop) ? 1 : 0) - (start ? 1 : 0);
            m_ovf  = drop || (m_ovf && !clr);
            if (hs) begin
                m_dv = 1; m_dd = sd; m_dl = (m_left == 1);
            end else if (m_dv && dr) begin
                m_dv = 0; m_dl = 0;
            end
            if (hs) m_left--;
            if (start) begin
                m_act = 1; m_left = BL;
            end else if (last) m_act = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        s_sr = int'(src_ready); s_dv = int'(dst_valid); s_dl = int'(dst_last);
        s_busy = int'(busy); s_ovf = int'(overflow); s_done = int'(burst_done);
        s_pend = int'(pending); s_dd = int'(dst_data);
        if (m_known) begin
            chk("m_src_ready", s_sr, int'(m_sr()));
            chk("m_dst_valid", s_dv, int'(m_dv));
            chk("m_dst_data", s_dd, int'(m_dd));
            chk("m_dst_last", s_dl, int'(m_dl));
            chk("m_burst_done", s_done, int'(m_dv && dr && m_dl));
            chk("m_busy", s_busy, int'(m_act));
            chk("m_pending", s_pend, m_pend);
            chk("m_overflow", s_ovf, int'(m_ovf));
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 0; clr = 0; sv = 0; dr = 0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int beats, first, last_c, peak, cnt;
        bit found, prev_stall;
        int prev_dd, nxt;

        // single request, cycle-exact expectations
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 1, 0};
        tbl[2] = '{0, 0, 0, 0, 1, 0, 0};
        tbl[3] = '{0, 1, 0, 0, 1, 0, 8'h13};
        tbl[4] = '{0, 1, 0, 0, 1, 0, 8'h14};
        tbl[5] = '{0, 1, 0, 0, 1, 0, 8'h15};
        tbl[6] = '{0, 1, 1, 1, 0, 0, 8'h16};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0};

        do_reset();
        step();
        chk("rst_dst_valid", s_dv, 0);
        chk("rst_pending", s_pend, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_overflow", s_ovf, 0);
        chk("rst_dst_data", s_dd, 0);

        // beats handshaken in cycle 2..5 carry sd of those cycles (0x10+cycle+1 offset below)
        sv = 1; dr = 1;
        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req;
            sd  = 8'(8'h11 + i);
            step();
            chk($sformatf("tbl%0d_dst_valid", i), s_dv, int'(tbl[i].dv));
            chk($sformatf("tbl%0d_dst_last", i), s_dl, int'(tbl[i].dl));
            chk($sformatf("tbl%0d_burst_done", i), s_done, int'(tbl[i].done));
            chk($sformatf("tbl%0d_busy", i), s_busy, int'(tbl[i].busy));
            chk($sformatf("tbl%0d_pending", i), s_pend, tbl[i].pend);
            if (tbl[i].dv) chk($sformatf("tbl%0d_dst_data", i), s_dd, tbl[i].dd);
        end
        req = 0;

        // four back-to-back requests: 16 gapless beats, no overflow
        do_reset();
        sv = 1; dr = 1;
        beats = 0; first = -1; last_c = -1; peak = 0;
        for (int c = 0; c < 60; c++) begin
            req = (c < 4);
            sd = 8'($urandom);
            step();
            if (s_pend > peak) peak = s_pend;
            if (s_dv == 1) begin
                beats++;
                if (first < 0) first = c;
                last_c = c;
            end
        end
        req = 0;
        chk("b2b_peak_pending", peak, 3);
        chk("b2b_beats", beats, 16);
        chk("b2b_no_gap", last_c - first + 1, 16);
        chk("b2b_overflow", s_ovf, 0);

        // request at MAX_PENDING in the cycle a new burst starts
        do_reset();
        sv = 0; dr = 1;
        for (int c = 0; c < 4; c++) begin
            req = 1;
            step();
        end
        req = 0;
        step();
        chk("max_setup_pending", s_pend, 3);
        sv = 1;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            req = m_act && m_left == 1 && m_sr();
            sd = 8'($urandom);
            step();
            if (req) found = 1;
            req = 0;
        end
        chk("max_start_found", int'(found), 1);
        step();
        chk("max_start_pending", s_pend, 3);
        chk("max_start_overflow", s_ovf, 0);

        // drops while pending is full, then clear priority
        sv = 0;
        req = 1; step(); step(); req = 0;
        step();
        chk("drop_overflow", s_ovf, 1);
        chk("drop_pending", s_pend, 3);
        req = 1; clr = 1; step(); req = 0; clr = 0;
        step();
        chk("drop_and_clear_overflow", s_ovf, 1);
        clr = 1; step(); clr = 0;
        step();
        chk("clear_overflow", s_ovf, 0);

        // reset after beat 2 with one request pending
        do_reset();
        sv = 1; dr = 1;
        req = 1; step(); req = 0;
        step();
        req = 1; step(); req = 0;
        step();
        step();
        chk("midrst_beat2_valid", s_dv, 1);
        chk("midrst_pending", s_pend, 1);
        rst_n = 0; step(); rst_n = 1;
        step();
        chk("midrst_dst_valid", s_dv, 0);
        chk("midrst_dst_last", s_dl, 0);
        chk("midrst_dst_data", s_dd, 0);
        chk("midrst_burst_done", s_done, 0);
        chk("midrst_busy", s_busy, 0);
        chk("midrst_pending", s_pend, 0);
        chk("midrst_overflow", s_ovf, 0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            cnt += s_dv + s_busy;
        end
        chk("midrst_quiet", cnt, 0);

        // dst_ready toggling: stalled beat holds, four ordered beats
        do_reset();
        sv = 1;
        req = 1; step(); req = 0;
        cnt = 0; prev_stall = 0; prev_dd = 0; nxt = 8'h40;
        for (int c = 0; c < 30; c++) begin
            dr = c[0];
            sd = 8'(nxt); nxt++;
            step();
            if (prev_stall && s_dv == 1) chk("stall_data_stable", s_dd, prev_dd);
            if (s_dv == 1 && dr) cnt++;
            prev_stall = (s_dv == 1) && !dr;
            prev_dd = s_dd;
        end
        chk("toggle_beats", cnt, 4);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            req = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 15) == 0);
            sv = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 3) != 0);
            sd = 8'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
